ram32_fifo_ctrl: RTL and testbench
==================================

// Module: ram32_fifo_ctrl
// PURPOSE
//  FIFO controller that sits directly upstream of the 32x8 single-port RAM (ram32) and owns its port.
//  - Turns a valid/ready push stream and a valid/ready pop stream into single-port RAM cycles
//    (wr_rd, addr, d_in) and captures the registered RAM read data into an output holding register.
//  - Gives the datapath a 32-deep byte FIFO built on the existing RAM.
// PARAMETERS
//  DW     8   data width; must match RAM data width
//  AW     5   address width; must match RAM address width
//  DEPTH  32  RAM words (2**AW); full threshold
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-low
//  in_valid   in   1      push request
//  in_data    in   DW     push data
//  in_ready   out  1      push accepted when in_valid && in_ready at rising edge
//  out_valid  out  1      output holding register holds a word
//  out_data   out  DW     head-of-FIFO word
//  out_ready  in   1      pop; word consumed when out_valid && out_ready at rising edge
//  ram_wr_rd  out  1      to RAM wr_rd: 1 = write, 0 = read
//  ram_addr   out  AW     to RAM addr
//  ram_d_in   out  DW     to RAM d_in
//  ram_d_out  in   DW     from RAM d_out; valid the cycle after a read is issued
//  ram_count  out  AW+1   words resident in RAM, 0..DEPTH; excludes in-flight and held words
//  full       out  1      ram_count == DEPTH
// BEHAVIOUR
//  Reset (rst low, async)
//  - wr_ptr = rd_ptr = 0, ram_count = 0, state = IDLE.
//  - out_valid = 0, out_data = 0, ram_wr_rd = 0, ram_addr = 0, ram_d_in = 0.
//  - Reset mid-operation discards RAM contents, the in-flight read and the held word.
//  - The RAM shares rst, so it clears too.
//  FSM, two states
//  - IDLE: rd_go = !out_valid && ram_count != 0.
//    - rd_go: drive ram_wr_rd = 0, ram_addr = rd_ptr; rd_ptr++, ram_count--; next state RD_WAIT.
//  - RD_WAIT: no read is issued. At the end of the cycle out_data <= ram_d_out, out_valid <= 1; next state IDLE.
//  Write path
//  - in_ready = !full && !rd_go. Computed from registered state only; no combinational path from out_ready.
//  - On accept: ram_wr_rd = 1, ram_addr = wr_ptr, ram_d_in = in_data; wr_ptr++, ram_count++.
//  - A write can proceed in RD_WAIT and in IDLE when rd_go = 0.
//  - The port does at most one operation per cycle. Read wins only when the output slot is free,
//    so a write gets the port at least every other cycle.
//  Port idle cycles
//  - ram_wr_rd = 0 (harmless read); ram_addr/ram_d_in hold their last values.
//  - ram_d_out is sampled only in RD_WAIT.
//  Pop
//  - out_valid && out_ready clears out_valid next cycle.
//  - The next read can issue at the earliest the cycle after the pop.
//  - Read latency: issue cycle N; RAM d_out updates at edge N; captured at edge N+1; out_valid high in cycle N+2.
//  Arithmetic and boundaries
//  - Pointers are AW bits and wrap 31 -> 0 naturally.
//  - ram_count changes by +1, -1 or 0. A simultaneous write and read is impossible, so no same-cycle +/-.
//  - Full: in_ready = 0; in_data is not written; pointers and count are unchanged.
//  - Empty (ram_count == 0): no read issues. out_valid stays at its current value.
//  - A push into an empty FIFO reaches out_valid no earlier than 3 cycles after the accept edge.
//  - Total capacity is DEPTH + 1 words: RAM plus the holding register.
// CONFIGURATION
//  FIFO_STATUS_EN defined
//  - Adds output almost_full (1 bit), = ram_count >= DEPTH-4.
//  - Adds output ovf_err (1 bit), sticky: set on in_valid && full at an edge; cleared only by rst.
//  FIFO_STATUS_EN undefined
//  - Both ports and their logic are absent. Behaviour is otherwise identical.
// TESTING
//  1. Reset then idle: in_valid = 0 for 10 cycles -> out_valid = 0, ram_count = 0, full = 0, in_ready = 1.
//  2. Push 0xA5 at edge 0 into empty FIFO -> ram_wr_rd = 1, addr 0; read addr 0 in cycle 1;
//     out_valid = 1, out_data = 0xA5 from cycle 3.
//  3. Push 0x00..0x20 with out_ready = 0 -> first word moves to the holding register.
//     - Pushes continue until ram_count = 32 and full = 1; total 33 accepted.
//     - A 34th push is held off with in_ready = 0.
//  4. Full FIFO, out_ready = 1 -> pops return 0x00..0x20 in order; ram_addr wraps 31 -> 0 on the next fill.
//  5. Continuous push and pop with out_ready = 1 -> no data loss or reorder.
//     - Port never has a write and a read in the same cycle; in_ready = 0 only in read-issue cycles or when full.
//  6. Assert rst in RD_WAIT with ram_count = 5 -> all outputs return to reset values immediately.
//     - With FIFO_STATUS_EN: push while full -> ovf_err = 1 until rst; almost_full = 1 at ram_count = 28.

Source files
------------

// File: rtl/ram32_fifo_ctrl_if.sv
// rtl/ram32_fifo_ctrl_if.sv - push/pop stream and RAM port bundle for ram32_fifo_ctrl
// almost_full and ovf_err exist only when FIFO_STATUS_EN is defined.
interface ram32_fifo_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 5
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          ram_wr_rd;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d_in;
  logic [DW-1:0] ram_d_out;
  logic [AW:0]   ram_count;
  logic          full;
`ifdef FIFO_STATUS_EN
  logic          almost_full;
  logic          ovf_err;

  modport master (
    output in_valid, in_data, out_ready, ram_d_out,
    input  in_ready, out_valid, out_data, ram_wr_rd, ram_addr, ram_d_in,
    input  ram_count, full, almost_full, ovf_err
  );
  modport slave (
    input  in_valid, in_data, out_ready, ram_d_out,
    output in_ready, out_valid, out_data, ram_wr_rd, ram_addr, ram_d_in,
    output ram_count, full, almost_full, ovf_err
  );
`else
  modport master (
    output in_valid, in_data, out_ready, ram_d_out,
    input  in_ready, out_valid, out_data, ram_wr_rd, ram_addr, ram_d_in,
    input  ram_count, full
  );
  modport slave (
    input  in_valid, in_data, out_ready, ram_d_out,
    output in_ready, out_valid, out_data, ram_wr_rd, ram_addr, ram_d_in,
    output ram_count, full
  );
`endif
endinterface

// File: rtl/ram32_fifo_ctrl.sv
// rtl/ram32_fifo_ctrl.sv - byte FIFO controller owning the single-port ram32 port
// Optional status outputs (almost_full, sticky ovf_err) under FIFO_STATUS_EN.
module ram32_fifo_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input logic              clk,
  input logic              rst,
  ram32_fifo_ctrl_if.slave bus
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] din_q;
  logic [DW-1:0] din_d;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q;
  logic [AW:0]   count_q;
  logic          full;
  logic          rd_go;
  logic          wr_en;

  assign full  = (count_q == DEPTH_C);
  assign rd_go = (state_q == IDLE) && !out_valid_q && (count_q != '0);

  // in_ready depends only on registered state; wr_en is also masked while rst is low
  assign bus.in_ready = !full && !rd_go;
  assign wr_en        = rst && bus.in_valid && !full && !rd_go;

  always_comb begin
    addr_d = addr_q;
    din_d  = din_q;
    if (wr_en) begin
      addr_d = wr_ptr_q;
      din_d  = bus.in_data;
    end else if (rd_go) begin
      addr_d = rd_ptr_q;
    end
  end

  assign bus.ram_wr_rd = wr_en;
  assign bus.ram_addr  = addr_d;
  assign bus.ram_d_in  = din_d;
  assign bus.ram_count = count_q;
  assign bus.full      = full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      addr_q <= addr_d;
      din_q  <= din_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        count_q  <= count_q + (AW+1)'(1);
      end else if (rd_go) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q  <= count_q - (AW+1)'(1);
      end
      case (state_q)
        IDLE: begin
          if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
          if (rd_go) state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          // RAM d_out is registered, so the word issued last cycle is valid now
          out_data_q  <= bus.ram_d_out;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FIFO_STATUS_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else if (bus.in_valid && full) ovf_q <= 1'b1;
  end

  assign bus.almost_full = (count_q >= (DEPTH_C - (AW+1)'(4)));
  assign bus.ovf_err     = ovf_q;
`endif

endmodule

// File: tb/tb_ram32_fifo_ctrl.sv
// tb/tb_ram32_fifo_ctrl.sv - directed self-checking bench for ram32_fifo_ctrl with a ram32 model
// Status checks are compiled in when FIFO_STATUS_EN is defined.
module tb_ram32_fifo_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ram32_fifo_ctrl_if #(.DW(8), .AW(5)) bus ();

  ram32_fifo_ctrl #(.DW(8), .AW(5), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 32x8 single-port RAM with registered read, sharing rst
  logic [7:0] mem [32];
  logic [7:0] ram_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      ram_q <= 8'h00;
    end else if (bus.ram_wr_rd) begin
      mem[bus.ram_addr] <= bus.ram_d_in;
    end else begin
      ram_q <= mem[bus.ram_addr];
    end
  end

  assign bus.ram_d_out = ram_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int         acc;
  int         cyc;
  int         pops;
  int         nxt;
  bit         ok;
  bit         prev_stall;
  bit         took;
  logic [7:0] sb [$];

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    // reset state
    repeat (3) step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_wr_rd", bus.ram_wr_rd, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_d_in", bus.ram_d_in, 0);
    chk("rst_count", bus.ram_count, 0);
    rst = 1'b1;

    // idle for 10 cycles
    repeat (10) step();
    chk("idle_out_valid", bus.out_valid, 0);
    chk("idle_count", bus.ram_count, 0);
    chk("idle_full", bus.full, 0);
    chk("idle_in_ready", bus.in_ready, 1);

    // single push 0xA5 and read latency
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    #1;
    chk("p1_in_ready", bus.in_ready, 1);
    chk("p1_wr_rd", bus.ram_wr_rd, 1);
    chk("p1_addr", bus.ram_addr, 0);
    chk("p1_d_in", bus.ram_d_in, 8'hA5);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("p1_rd_wr_rd", bus.ram_wr_rd, 0);
    chk("p1_rd_addr", bus.ram_addr, 0);
    chk("p1_rd_in_ready", bus.in_ready, 0);
    chk("p1_rd_count", bus.ram_count, 1);
    step();
    chk("p1_wait_count", bus.ram_count, 0);
    chk("p1_wait_valid", bus.out_valid, 0);
    chk("p1_wait_in_ready", bus.in_ready, 1);
    step();
    chk("p1_out_valid", bus.out_valid, 1);
    chk("p1_out_data", bus.out_data, 8'hA5);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    #1;
    chk("p1_popped", bus.out_valid, 0);

`ifdef FIFO_STATUS_EN
    chk("st_af_low", bus.almost_full, 0);
    chk("st_ovf_low", bus.ovf_err, 0);
`endif

    // fill: 33 accepted, write address runs 1..31,0,1
    acc = 0;
    cyc = 0;
    bus.in_valid = 1'b1;
    while (acc < 33 && cyc < 100) begin
      bus.in_data = acc[7:0];
      #1;
      took = 1'b0;
      if (bus.in_ready) begin
        chk("fill_wr_rd", bus.ram_wr_rd, 1);
        chk("fill_addr", bus.ram_addr, (acc + 1) % 32);
        acc++;
        took = 1'b1;
      end
      step();
      cyc++;
`ifdef FIFO_STATUS_EN
      if (took && acc == 28) chk("st_af_27", bus.almost_full, 0);
      if (took && acc == 29) begin
        chk("st_count_28", bus.ram_count, 28);
        chk("st_af_28", bus.almost_full, 1);
      end
`endif
    end
    chk("fill_accepted", acc, 33);
    chk("fill_count", bus.ram_count, 32);
    chk("fill_full", bus.full, 1);
    chk("fill_out_valid", bus.out_valid, 1);
    chk("fill_out_data", bus.out_data, 8'h00);

    // 34th push held off
    bus.in_data = 8'h55;
    #1;
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_wr_rd", bus.ram_wr_rd, 0);
    step();
    step();
    chk("full_count_hold", bus.ram_count, 32);
    bus.in_valid = 1'b0;
`ifdef FIFO_STATUS_EN
    chk("st_ovf_set", bus.ovf_err, 1);
`endif

    // drain: 0x00..0x20 in order
    bus.out_ready = 1'b1;
    pops = 0;
    cyc = 0;
    while (pops < 33 && cyc < 200) begin
      #1;
      if (bus.out_valid) begin
        chk("drain_data", bus.out_data, pops);
        pops++;
      end
      step();
      cyc++;
    end
    chk("drain_pops", pops, 33);
    step();
    step();
    chk("drain_count", bus.ram_count, 0);
    chk("drain_out_valid", bus.out_valid, 0);
`ifdef FIFO_STATUS_EN
    chk("st_ovf_sticky", bus.ovf_err, 1);
`endif

    // continuous push and pop
    nxt = 0;
    pops = 0;
    cyc = 0;
    ok = 1'b1;
    prev_stall = 1'b0;
    while (pops < 32 && cyc < 400) begin
      bus.in_valid = (nxt < 32);
      bus.in_data  = 8'h40 + nxt[7:0];
      #1;
      if (bus.in_valid && bus.in_ready) begin
        if (!bus.ram_wr_rd) ok = 1'b0;
        sb.push_back(bus.in_data);
        nxt++;
      end
      if (!bus.in_ready && !bus.full) begin
        if (prev_stall || bus.ram_wr_rd) ok = 1'b0;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (bus.out_valid) begin
        chk("stream_data", bus.out_data, (sb.size() != 0) ? {24'h0, sb[0]} : 32'hFFFF_FFFF);
        if (sb.size() != 0) void'(sb.pop_front());
        pops++;
      end
      step();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("stream_pops", pops, 32);
    chk("stream_port_rules", ok, 1);

    // reset in RD_WAIT with 5 words resident
    acc = 0;
    cyc = 0;
    bus.in_valid = 1'b1;
    while (acc < 7 && cyc < 40) begin
      bus.in_data = 8'h90 + acc[7:0];
      #1;
      if (bus.in_ready) acc++;
      step();
      cyc++;
    end
    bus.in_valid = 1'b0;
    #1;
    chk("r6_count6", bus.ram_count, 6);
    chk("r6_held", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    #1;
    chk("r6_rd_issue", bus.in_ready, 0);
    step();
    chk("r6_count5", bus.ram_count, 5);
    rst = 1'b0;
    #1;
    chk("r6_out_valid", bus.out_valid, 0);
    chk("r6_out_data", bus.out_data, 0);
    chk("r6_wr_rd", bus.ram_wr_rd, 0);
    chk("r6_addr", bus.ram_addr, 0);
    chk("r6_d_in", bus.ram_d_in, 0);
    chk("r6_count", bus.ram_count, 0);
    chk("r6_full", bus.full, 0);
`ifdef FIFO_STATUS_EN
    chk("st_ovf_cleared", bus.ovf_err, 0);
    chk("st_af_cleared", bus.almost_full, 0);
`endif
    step();
    rst = 1'b1;
    repeat (3) step();
    chk("r6_post_in_ready", bus.in_ready, 1);
    chk("r6_post_out_valid", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
